icache_fill: RTL and testbench



---
 rtl/icache_fill_pkg.sv | 20 ++
 rtl/icache_fill.sv | 99 +++++++++
 tb/tb_icache_fill.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_fill_pkg.sv
// Shared types for the instruction cache and its fill engine: word/address
// types, icache depth and the fill FSM state encoding.
package icache_fill_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam int ICACHE_DEPTH = 32;

  typedef enum logic [1:0] {
    FILL_IDLE  = 2'd0,
    FILL_REQ   = 2'd1,
    FILL_WRITE = 2'd2,
    FILL_DONE  = 2'd3
  } fill_state_t;

endpackage

// File: rtl/icache_fill.sv
// Icache fill engine: reads a block of consecutive words from memory over a
// req/ack handshake and writes them into icache entries 0..count-1.
module icache_fill
  import icache_fill_pkg::*;
#(
  parameter int DEPTH = ICACHE_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  addr_t       base_addr,
  input  logic [IDX_W:0] count,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        mem_req,
  output addr_t       mem_addr,
  input  logic        mem_ack,
  input  word_t       mem_rdata,
  output logic        icache_write,
  output addr_t       icache_waddr,
  output word_t       icache_wdata,
  output fill_state_t state_dbg
);

  // Handshake: mem_req is high for every REQ cycle and mem_addr is held
  // until the cycle in which mem_ack=1 is seen; that cycle completes the
  // transfer and mem_rdata is captured. mem_ack outside REQ is ignored.

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ONE_C   = (IDX_W+1)'(1);

  fill_state_t      state, state_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   cnt;
  addr_t            base;
  word_t            data;
  logic             last;

  assign last = ({1'b0, idx} == (cnt - ONE_C));

  always_comb begin
    state_next = state;
    if (abort && (state != FILL_IDLE)) begin
      state_next = FILL_IDLE;
    end else begin
      case (state)
        FILL_IDLE: begin
          if (start) state_next = (count == '0) ? FILL_DONE : FILL_REQ;
        end
        FILL_REQ: begin
          if (mem_ack) state_next = FILL_WRITE;
        end
        FILL_WRITE: begin
          state_next = last ? FILL_DONE : FILL_REQ;
        end
        FILL_DONE: begin
          state_next = FILL_IDLE;
        end
        default: state_next = FILL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= FILL_IDLE;
      idx   <= '0;
      cnt   <= '0;
      base  <= '0;
      data  <= '0;
    end else begin
      state <= state_next;
      if ((state == FILL_IDLE) && start && (count != '0)) begin
        base <= base_addr & ~addr_t'(3);
        cnt  <= (count > DEPTH_C) ? DEPTH_C : count;
        idx  <= '0;
      end
      if ((state == FILL_REQ) && mem_ack && !abort) begin
        data <= mem_rdata;
      end
      if ((state == FILL_WRITE) && !abort && !last) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Abort suppresses the write and the done pulse in the cycle it is seen.
  assign busy         = (state == FILL_REQ) || (state == FILL_WRITE);
  assign done         = (state == FILL_DONE) && !abort;
  assign mem_req      = (state == FILL_REQ);
  assign mem_addr     = mem_req ? (base + addr_t'({idx, 2'b00})) : '0;
  assign icache_write = (state == FILL_WRITE) && !abort;
  assign icache_waddr = addr_t'(idx);
  assign icache_wdata = data;
  assign state_dbg    = state;

endmodule

// File: tb/tb_icache_fill.sv
// Directed bench for icache_fill: cycle-accurate memory responder, write/done
// logs per fill and hand-computed expectations.
module tb_icache_fill;
  import icache_fill_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  addr_t       base_addr;
  logic [5:0]  count;
  logic        abort;
  logic        busy;
  logic        done;
  logic        mem_req;
  addr_t       mem_addr;
  logic        mem_ack;
  word_t       mem_rdata;
  logic        icache_write;
  addr_t       icache_waddr;
  word_t       icache_wdata;
  fill_state_t state_dbg;

  always #5 clk = ~clk;

  icache_fill dut (
    .clk(clk), .nrst(nrst), .start(start), .base_addr(base_addr),
    .count(count), .abort(abort), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .icache_write(icache_write),
    .icache_waddr(icache_waddr), .icache_wdata(icache_wdata),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // per-fill logs, indexed by write order or by cycle number
  int          wr_n;
  logic [31:0] wr_idx  [64];
  logic [31:0] wr_data [64];
  int          wr_cyc  [64];
  addr_t       req_addr[$];
  int          done_cnt;
  int          done_cyc;
  int          stab_err;
  bit          busy_at [128];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start sampled at edge 0; cycle c is the period after edge c-1.
  task automatic run_fill(input addr_t base, input logic [5:0] cnt, input int delay,
                          input bit tied, input int ncyc, input int abort_cyc,
                          input int rst_cyc, input int pulse_cyc);
    addr_t base_al;
    addr_t hold;
    bit    in_req;
    int    wait_n;
    base_al  = base & ~addr_t'(3);
    wr_n     = 0;
    done_cnt = 0;
    done_cyc = -1;
    stab_err = 0;
    in_req   = 1'b0;
    wait_n   = 0;
    hold     = '0;
    req_addr.delete();
    for (int i = 0; i < 128; i++) busy_at[i] = 1'b0;
    @(negedge clk);
    nrst = 1'b1; abort = 1'b0; start = 1'b1;
    base_addr = base; count = cnt; mem_ack = tied; mem_rdata = '0;
    @(posedge clk);
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      start = (cyc == pulse_cyc);
      abort = (cyc == abort_cyc);
      nrst  = (cyc != rst_cyc);
      if (mem_req) begin
        if (!in_req) begin
          req_addr.push_back(mem_addr);
          hold   = mem_addr;
          in_req = 1'b1;
          wait_n = 0;
        end else if (mem_addr !== hold) begin
          stab_err++;
        end
        mem_rdata = 32'hA0 + ((mem_addr - base_al) >> 2);
        mem_ack   = tied || (wait_n == delay);
        if (mem_ack) in_req = 1'b0;
        wait_n++;
      end else begin
        in_req  = 1'b0;
        mem_ack = tied;
      end
      #1;
      busy_at[cyc] = busy;
      if (icache_write && wr_n < 64) begin
        wr_idx[wr_n]  = icache_waddr;
        wr_data[wr_n] = icache_wdata;
        wr_cyc[wr_n]  = cyc;
        wr_n++;
      end
      if (done) begin
        if (done_cnt == 0) done_cyc = cyc;
        done_cnt++;
      end
    end
    start = 1'b0; abort = 1'b0; nrst = 1'b1; mem_ack = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; start = 1'b1; base_addr = 32'h100; count = 6'd4;
    abort = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

    // reset held two cycles with start high
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", mem_req, 0);
    check("rst_write", icache_write, 0);
    check("rst_state", state_dbg, FILL_IDLE);
    nrst = 1'b1; start = 1'b0;
    @(negedge clk);
    check("idle_req", mem_req, 0);
    check("idle_busy", busy, 0);

    // zero-wait fill, ack tied high
    run_fill(32'h100, 6'd4, 0, 1'b1, 12, -1, -1, -1);
    check("zw_nwr", wr_n, 4);
    check("zw_nreq", req_addr.size(), 4);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
    for (int i = 0; i < wr_n && i < 4; i++) begin
      check("zw_addr", req_addr[i], 32'h100 + 4 * i);
      check("zw_idx", wr_idx[i], i);
      check("zw_data", wr_data[i], exp_q.pop_front());
      check("zw_cyc", wr_cyc[i], 2 + 2 * i);
    end
    exp_q.delete();
    check("zw_done_cyc", done_cyc, 9);
    check("zw_done_cnt", done_cnt, 1);
    check("zw_busy9", busy_at[9], 0);

    // three wait states per word, unaligned base
    run_fill(32'h203, 6'd4, 3, 1'b0, 25, -1, -1, -1);
    check("ws_nwr", wr_n, 4);
    check("ws_addr0", req_addr.size() > 0 ? req_addr[0] : 32'hX, 32'h200);
    check("ws_stable", stab_err, 0);
    check("ws_cyc0", wr_cyc[0], 5);
    check("ws_cyc3", wr_cyc[3], 20);
    check("ws_data3", wr_data[3], 32'hA3);
    check("ws_done_cyc", done_cyc, 21);

    // count of zero is a no-op that still reports done
    run_fill(32'h100, 6'd0, 0, 1'b1, 4, -1, -1, -1);
    check("c0_done_cyc", done_cyc, 1);
    check("c0_nreq", req_addr.size(), 0);
    check("c0_nwr", wr_n, 0);
    check("c0_busy1", busy_at[1], 0);

    // count above depth saturates
    run_fill(32'h1000, 6'd40, 0, 1'b1, 70, -1, -1, -1);
    check("sat_nwr", wr_n, 32);
    check("sat_last_idx", wr_idx[31], 31);
    check("sat_last_data", wr_data[31], 32'hBF);
    check("sat_done_cyc", done_cyc, 65);

    // address wraps at the top of the space
    run_fill(32'hFFFF_FFFC, 6'd2, 0, 1'b1, 8, -1, -1, -1);
    check("wrap_nreq", req_addr.size(), 2);
    check("wrap_addr0", req_addr.size() > 0 ? req_addr[0] : 32'hX, 32'hFFFF_FFFC);
    check("wrap_addr1", req_addr.size() > 1 ? req_addr[1] : 32'hX, 32'h0);
    check("wrap_data1", wr_data[1], 32'hA1);

    // abort in the REQ of word 2
    run_fill(32'h100, 6'd4, 0, 1'b1, 10, 5, -1, -1);
    check("abr_nwr", wr_n, 2);
    check("abr_idx1", wr_idx[1], 1);
    check("abr_done", done_cnt, 0);
    check("abr_busy5", busy_at[5], 1);
    check("abr_busy6", busy_at[6], 0);

    // abort during the WRITE of word 1
    run_fill(32'h100, 6'd4, 0, 1'b1, 10, 4, -1, -1);
    check("abw_nwr", wr_n, 1);
    check("abw_idx0", wr_idx[0], 0);
    check("abw_done", done_cnt, 0);
    check("abw_busy5", busy_at[5], 0);

    // start pulse mid-fill is ignored
    run_fill(32'h100, 6'd4, 0, 1'b1, 12, -1, -1, 3);
    check("sb_nwr", wr_n, 4);
    check("sb_nreq", req_addr.size(), 4);
    check("sb_addr3", req_addr.size() > 3 ? req_addr[3] : 32'hX, 32'h10C);
    check("sb_done_cyc", done_cyc, 9);
    check("sb_done_cnt", done_cnt, 1);

    // reset mid-fill, then a fresh fill
    run_fill(32'h100, 6'd4, 0, 1'b1, 10, -1, 5, -1);
    check("rm_nwr", wr_n, 2);
    check("rm_done", done_cnt, 0);
    check("rm_busy6", busy_at[6], 0);
    run_fill(32'h100, 6'd2, 0, 1'b1, 8, -1, -1, -1);
    check("rc_nwr", wr_n, 2);
    check("rc_cyc0", wr_cyc[0], 2);
    check("rc_idx0", wr_idx[0], 0);
    check("rc_data1", wr_data[1], 32'hA1);
    check("rc_done_cyc", done_cyc, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
